// File: rtl/lcd_hw_ctrl.sv
// lcd_hw_ctrl
// Write-only sequencer for an HD44780-compatible 16x2 LCD on an 8-bit bus.
// After reset it waits out the panel power-up time, then issues the four
// init writes (0x38, 0x0C, 0x01, 0x06). After that it accepts one byte per
// valid/ready handshake. Each write drives RS/DATA, waits the setup time,
// pulses EN, holds RS/DATA, then waits the execution time before the next
// write.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   in_valid/in_ready     request handshake (transfer on valid&&ready)
//   in_rs, in_data        0 = instruction / 1 = character, and the byte
//   init_done             init sequence complete (sticky until reset)
//   busy                  high whenever the sequencer is not idle
//   LCD_ON, LCD_BLON      panel power (1) and backlight (BACKLIGHT)
//   LCD_EN, LCD_RW        enable strobe, read/write (always write)
//   LCD_RS, LCD_DATA      register select and data bus
module lcd_hw_ctrl #(
  parameter int unsigned PWRUP_CYC     = 750000,
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned EN_CYC        = 25,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned LONG_EXEC_CYC = 82000,
  parameter bit          BACKLIGHT     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic       busy,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_EN,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic [7:0] LCD_DATA
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = max2(max2(max2(PWRUP_CYC, SETUP_CYC), max2(EN_CYC, HOLD_CYC)),
                                         max2(EXEC_CYC, LONG_EXEC_CYC));
  // The counter runs 0 .. count-1 in each timed state.
  localparam int unsigned CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_LOAD,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_EXEC,
    S_IDLE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic             cnt_last;
  logic [1:0]       idx;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             long_exec;

  function automatic logic [7:0] init_rom(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Clear (0x01) and Home (0x02/0x03) instructions need the long wait.
  assign long_exec = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  always_comb begin
    last_cnt = '0;
    case (state)
      S_PWRUP: last_cnt = CNT_W'(PWRUP_CYC - 1);
      S_SETUP: last_cnt = CNT_W'(SETUP_CYC - 1);
      S_EN_HI: last_cnt = CNT_W'(EN_CYC - 1);
      S_HOLD:  last_cnt = CNT_W'(HOLD_CYC - 1);
      S_EXEC:  last_cnt = long_exec ? CNT_W'(LONG_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);
      default: last_cnt = '0;
    endcase
  end

  assign cnt_last = (cnt == last_cnt);

  // State register and per-state cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_PWRUP;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == S_IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_PWRUP: if (cnt_last) state_next = S_LOAD;
      S_LOAD:  state_next = S_SETUP;
      S_SETUP: if (cnt_last) state_next = S_EN_HI;
      S_EN_HI: if (cnt_last) state_next = S_HOLD;
      S_HOLD:  if (cnt_last) state_next = S_EXEC;
      S_EXEC:  if (cnt_last) state_next = (!init_done && idx != 2'd3) ? S_LOAD : S_IDLE;
      S_IDLE:  if (in_valid) state_next = S_SETUP;
      default: state_next = S_PWRUP;
    endcase
  end

  // Bus registers and init progress. RS/DATA only move in LOAD or on
  // acceptance, so they are stable through EN_HI and HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      init_done <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      case (state)
        S_PWRUP: idx <= '0;
        S_LOAD: begin
          rs_q   <= 1'b0;
          data_q <= init_rom(idx);
        end
        S_EXEC: begin
          if (cnt_last && !init_done) begin
            if (idx == 2'd3) begin
              init_done <= 1'b1;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        S_IDLE: begin
          if (in_valid) begin
            rs_q   <= in_rs;
            data_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    LCD_EN   = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state)
      S_EN_HI: LCD_EN = 1'b1;
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      default: ;
    endcase
  end

  assign LCD_ON   = 1'b1;
  assign LCD_BLON = BACKLIGHT;
  assign LCD_RW   = 1'b0;
  assign LCD_RS   = rs_q;
  assign LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd_hw_ctrl.sv
// tb_lcd_hw_ctrl
// Directed bench for lcd_hw_ctrl with short timing parameters
// (PWRUP=10, SETUP=2, EN=3, HOLD=2, EXEC=5, LONG_EXEC=20).
// A negedge monitor logs every EN pulse (start cycle, RS, DATA, width)
// and counts any RS/DATA movement while EN is high or in the two hold
// cycles after it falls.
module tb_lcd_hw_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       init_done;
  logic       busy;
  logic       LCD_ON;
  logic       LCD_BLON;
  logic       LCD_EN;
  logic       LCD_RW;
  logic       LCD_RS;
  logic [7:0] LCD_DATA;

  lcd_hw_ctrl #(
    .PWRUP_CYC    (10),
    .SETUP_CYC    (2),
    .EN_CYC       (3),
    .HOLD_CYC     (2),
    .EXEC_CYC     (5),
    .LONG_EXEC_CYC(20),
    .BACKLIGHT    (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rs    (in_rs),
    .in_data  (in_data),
    .init_done(init_done),
    .busy     (busy),
    .LCD_ON   (LCD_ON),
    .LCD_BLON (LCD_BLON),
    .LCD_EN   (LCD_EN),
    .LCD_RW   (LCD_RW),
    .LCD_RS   (LCD_RS),
    .LCD_DATA (LCD_DATA)
  );

  always #5 clk = ~clk;

  // Expected timing, in cycles.
  // Init: first EN after 10 PWRUP + 1 LOAD + 2 SETUP edges -> release+13.
  // Init pulse pitch: EN3 + HOLD2 + EXEC5 + LOAD1 + SETUP2 = 13,
  // 28 after the Clear (EXEC 20). Ready after last pulse: 3+2+5 = 10.
  localparam int NORM_LAT = 12;  // 2+3+2+5 from acceptance to ready
  localparam int LONG_LAT = 27;  // 2+3+2+20
  localparam int STREAM_GAP = NORM_LAT + 1;  // ready cycle is the next accept cycle

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         rise_cyc[$];
  logic       rise_rs[$];
  logic [7:0] rise_data[$];
  int         widths[$];
  logic       en_prev = 1'b0;
  int         hold_left = 0;
  logic       snap_rs = 1'b0;
  logic [7:0] snap_data = 8'h00;
  int         unstable = 0;

  always @(negedge clk) begin
    if (reset) begin
      en_prev   = 1'b0;
      hold_left = 0;
    end else begin
      if (LCD_EN && !en_prev) begin
        rise_cyc.push_back(cyc);
        rise_rs.push_back(LCD_RS);
        rise_data.push_back(LCD_DATA);
        widths.push_back(0);
        snap_rs   = LCD_RS;
        snap_data = LCD_DATA;
      end
      if (LCD_EN) widths[widths.size()-1] = widths[widths.size()-1] + 1;
      if (!LCD_EN && en_prev) hold_left = 2;
      if ((LCD_EN || hold_left > 0) && (LCD_RS !== snap_rs || LCD_DATA !== snap_data))
        unstable++;
      if (!LCD_EN && hold_left > 0) hold_left--;
      en_prev = LCD_EN;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at a negedge where in_ready is high, or after the budget runs out.
  task automatic wait_ready(input int limit, output int c);
    int n;
    n = 0;
    while (!in_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
    chk("ready_wait", in_ready, 1'b1);
  endtask

  // Releases reset and checks the power-up wait and the four init writes.
  task automatic release_and_check_init();
    int          base;
    int          ref_c;
    int          r;
    int          init_t[4];
    logic [7:0]  init_d[4];
    init_t = '{13, 26, 39, 67};
    init_d = '{8'h38, 8'h0C, 8'h01, 8'h06};
    base = rise_cyc.size();
    reset = 1'b0;
    ref_c = cyc;
    @(negedge clk);
    chk("init_busy", busy, 1'b1);
    chk("init_ready_low", in_ready, 1'b0);
    wait_ready(200, r);
    chk("init_pulse_count", rise_cyc.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("init%0d_time", i), rise_cyc[base+i] - ref_c, init_t[i]);
      chk($sformatf("init%0d_rs", i), rise_rs[base+i], 1'b0);
      chk($sformatf("init%0d_data", i), rise_data[base+i], init_d[i]);
      chk($sformatf("init%0d_width", i), widths[base+i], 3);
    end
    chk("init_ready_time", r - ref_c, 77);
    chk("init_done_high", init_done, 1'b1);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic write_byte(input logic rs, input logic [7:0] d, output int ta);
    int r;
    wait_ready(200, r);
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    @(negedge clk);
    ta = cyc;
    chk("ready_falls", in_ready, 1'b0);
    chk("busy_after_accept", busy, 1'b1);
    in_valid = 1'b0;
    in_rs    = ~rs;
    in_data  = ~d;
  endtask

  task automatic xfer(input string tag, input logic rs, input logic [7:0] d, input int lat);
    int ta;
    int r;
    int base;
    base = rise_cyc.size();
    write_byte(rs, d, ta);
    wait_ready(200, r);
    chk({tag, "_pulses"}, rise_cyc.size() - base, 1);
    chk({tag, "_en_time"}, rise_cyc[base] - ta, 2);
    chk({tag, "_rs"}, rise_rs[base], rs);
    chk({tag, "_data"}, rise_data[base], d);
    chk({tag, "_width"}, widths[base], 3);
    chk({tag, "_ready_lat"}, r - ta, lat);
  endtask

  initial begin
    int ta;
    int r;
    int base;
    int n;

    // Reset with in_valid already held: init must ignore it.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_en", LCD_EN, 1'b0);
    chk("rst_rs", LCD_RS, 1'b0);
    chk("rst_data", LCD_DATA, 8'h00);
    chk("rst_rw", LCD_RW, 1'b0);
    chk("rst_on", LCD_ON, 1'b1);
    chk("rst_blon", LCD_BLON, 1'b1);

    release_and_check_init();

    // The held request is taken on the first ready cycle.
    base = rise_cyc.size();
    @(negedge clk);
    ta = cyc;
    chk("held_accept", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_ready(200, r);
    chk("held_pulses", rise_cyc.size() - base, 1);
    chk("held_en_time", rise_cyc[base] - ta, 2);
    chk("held_rs", rise_rs[base], 1'b1);
    chk("held_data", rise_data[base], 8'h55);
    chk("held_ready_lat", r - ta, NORM_LAT);

    xfer("char_41", 1'b1, 8'h41, NORM_LAT);
    xfer("home_02", 1'b0, 8'h02, LONG_LAT);
    xfer("ddram_80", 1'b0, 8'h80, NORM_LAT);
    xfer("clear_01", 1'b0, 8'h01, LONG_LAT);
    xfer("home_03", 1'b0, 8'h03, LONG_LAT);
    xfer("instr_00", 1'b0, 8'h00, NORM_LAT);
    xfer("char_01", 1'b1, 8'h01, NORM_LAT);

    // Stream "HI" with in_valid held throughout.
    base = rise_cyc.size();
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'h48;
    wait_ready(200, r);
    @(negedge clk);
    in_data = 8'h49;
    wait_ready(200, r);
    @(negedge clk);
    in_valid = 1'b0;
    wait_ready(200, r);
    chk("hi_pulses", rise_cyc.size() - base, 2);
    chk("hi_gap", rise_cyc[base+1] - rise_cyc[base], STREAM_GAP);
    chk("hi_data0", rise_data[base], 8'h48);
    chk("hi_data1", rise_data[base+1], 8'h49);
    chk("hi_width1", widths[base+1], 3);
    chk("bus_stable", unstable, 0);

    // Reset in the second cycle of EN high.
    write_byte(1'b1, 8'h5A, ta);
    n = 0;
    while (!LCD_EN && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_en", LCD_EN, 1'b1);
    @(negedge clk);
    chk("en_2nd_cycle", LCD_EN, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_en", LCD_EN, 1'b0);
    chk("mid_rst_init_done", init_done, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b0);
    chk("mid_rst_data", LCD_DATA, 8'h00);
    @(negedge clk);
    release_and_check_init();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
